// File: rtl/mem_access_unit.sv
// Initiator side of the byte-enabled data RAM port: accepts one MIPS load/store per
// handshake, drives lane-aligned RAM controls and returns extended load data.
module mem_access_unit #(
    parameter int unsigned NB_ADDR    = 32,
    parameter int unsigned RAM_ADDR_W = 10,
    parameter int unsigned NB_COL     = 4,
    parameter int unsigned COL_WIDTH  = 8
) (
    input  logic                    clka,
    input  logic                    rsta_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [NB_ADDR-1:0]      req_addr,
    input  logic [NB_COL*COL_WIDTH-1:0] req_wdata,
    output logic                    rsp_valid,
    output logic [NB_COL*COL_WIDTH-1:0] rsp_rdata,
    output logic                    rsp_misalign,
    output logic                    ram_en,
    output logic [NB_COL-1:0]       ram_we,
    output logic [RAM_ADDR_W-1:0]   ram_addr,
    output logic [NB_COL*COL_WIDTH-1:0] ram_din,
    input  logic [NB_COL*COL_WIDTH-1:0] ram_dout
);

    localparam int unsigned NB_DATA = NB_COL * COL_WIDTH;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]            state, state_nxt;
    logic [1:0]            op_off, op_off_nxt;
    logic [1:0]            op_size, op_size_nxt;
    logic                  op_uns, op_uns_nxt;
    logic                  op_write, op_write_nxt;
    logic                  req_ready_nxt;
    logic                  rsp_valid_nxt;
    logic [NB_DATA-1:0]    rsp_rdata_nxt;
    logic                  rsp_misalign_nxt;
    logic                  ram_en_nxt;
    logic [NB_COL-1:0]     ram_we_nxt;
    logic [RAM_ADDR_W-1:0] ram_addr_nxt;
    logic [NB_DATA-1:0]    ram_din_nxt;

    logic                  misalign_c;
    logic [7:0]            load_byte_c;
    logic [15:0]           load_half_c;
    logic [NB_DATA-1:0]    load_data_c;
    logic                  unused_addr_c;

    assign unused_addr_c = &{1'b0, req_addr[NB_ADDR-1:RAM_ADDR_W+2]};

    // Alignment check on the live request; only consulted at the handshake
    always_comb begin
        misalign_c = 1'b0;
        case (req_size)
            SZ_BYTE: misalign_c = 1'b0;
            SZ_HALF: misalign_c = req_addr[0];
            SZ_WORD: misalign_c = (req_addr[1:0] != 2'b00);
            default: misalign_c = 1'b1;
        endcase
    end

    // Lane select and extension of the RAM read word using the latched operation
    always_comb begin
        load_byte_c = 8'h00;
        case (op_off)
            2'd0:    load_byte_c = ram_dout[7:0];
            2'd1:    load_byte_c = ram_dout[15:8];
            2'd2:    load_byte_c = ram_dout[23:16];
            default: load_byte_c = ram_dout[31:24];
        endcase
        load_half_c = op_off[1] ? ram_dout[31:16] : ram_dout[15:0];
        load_data_c = ram_dout;
        case (op_size)
            SZ_BYTE: load_data_c = {{24{~op_uns & load_byte_c[7]}}, load_byte_c};
            SZ_HALF: load_data_c = {{16{~op_uns & load_half_c[15]}}, load_half_c};
            default: load_data_c = ram_dout;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt        = state;
        op_off_nxt       = op_off;
        op_size_nxt      = op_size;
        op_uns_nxt       = op_uns;
        op_write_nxt     = op_write;
        req_ready_nxt    = req_ready;
        rsp_valid_nxt    = rsp_valid;
        rsp_rdata_nxt    = rsp_rdata;
        rsp_misalign_nxt = rsp_misalign;
        ram_en_nxt       = ram_en;
        ram_we_nxt       = ram_we;
        ram_addr_nxt     = ram_addr;
        ram_din_nxt      = ram_din;
        case (state)
            ST_IDLE: begin
                if (req_valid && req_ready) begin
                    op_off_nxt    = req_addr[1:0];
                    op_size_nxt   = req_size;
                    op_uns_nxt    = req_unsigned;
                    op_write_nxt  = req_write;
                    req_ready_nxt = 1'b0;
                    if (misalign_c) begin
                        state_nxt        = ST_RESP;
                        rsp_valid_nxt    = 1'b1;
                        rsp_misalign_nxt = 1'b1;
                        rsp_rdata_nxt    = '0;
                    end else begin
                        state_nxt    = ST_ACCESS;
                        ram_en_nxt   = 1'b1;
                        ram_addr_nxt = req_addr[RAM_ADDR_W+1:2];
                        ram_we_nxt   = '0;
                        if (req_write) begin
                            case (req_size)
                                SZ_BYTE: begin
                                    ram_we_nxt  = NB_COL'(1) << req_addr[1:0];
                                    ram_din_nxt = {4{req_wdata[7:0]}};
                                end
                                SZ_HALF: begin
                                    ram_we_nxt  = NB_COL'(3) << req_addr[1:0];
                                    ram_din_nxt = {2{req_wdata[15:0]}};
                                end
                                default: begin
                                    ram_we_nxt  = '1;
                                    ram_din_nxt = req_wdata;
                                end
                            endcase
                        end
                    end
                end
            end
            ST_ACCESS: begin
                state_nxt     = ST_RESP;
                ram_en_nxt    = 1'b0;
                ram_we_nxt    = '0;
                rsp_valid_nxt = 1'b1;
                rsp_rdata_nxt = op_write ? '0 : load_data_c;
            end
            ST_RESP: begin
                state_nxt        = ST_IDLE;
                req_ready_nxt    = 1'b1;
                rsp_valid_nxt    = 1'b0;
                rsp_misalign_nxt = 1'b0;
            end
            default: begin
                state_nxt        = ST_IDLE;
                req_ready_nxt    = 1'b1;
                rsp_valid_nxt    = 1'b0;
                rsp_misalign_nxt = 1'b0;
                ram_en_nxt       = 1'b0;
                ram_we_nxt       = '0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state        <= ST_IDLE;
            op_off       <= '0;
            op_size      <= '0;
            op_uns       <= 1'b0;
            op_write     <= 1'b0;
            req_ready    <= 1'b1;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_misalign <= 1'b0;
            ram_en       <= 1'b0;
            ram_we       <= '0;
            ram_addr     <= '0;
            ram_din      <= '0;
        end else begin
            state        <= state_nxt;
            op_off       <= op_off_nxt;
            op_size      <= op_size_nxt;
            op_uns       <= op_uns_nxt;
            op_write     <= op_write_nxt;
            req_ready    <= req_ready_nxt;
            rsp_valid    <= rsp_valid_nxt;
            rsp_rdata    <= rsp_rdata_nxt;
            rsp_misalign <= rsp_misalign_nxt;
            ram_en       <= ram_en_nxt;
            ram_we       <= ram_we_nxt;
            ram_addr     <= ram_addr_nxt;
            ram_din      <= ram_din_nxt;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: byte-enabled RAM model on negedge, scoreboard of
// expected responses checked by a response monitor.
module tb_mem_access_unit;

    logic        clka = 1'b0;
    logic        rsta_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_misalign;
    logic        ram_en;
    logic [3:0]  ram_we;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout = 32'h0;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        int          hs;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic        en_seen = 1'b0;
    logic [31:0] mem [0:1023];

    mem_access_unit dut (
        .clka(clka), .rsta_n(rsta_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_misalign(rsp_misalign), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clka = ~clka;

    always @(posedge clka) begin
        cyc <= cyc + 1;
        if (ram_en) en_seen <= 1'b1;
    end

    // Byte-enabled RAM, read-first, captured on negedge
    always @(negedge clka) begin
        if (ram_en) begin
            ram_dout <= mem[ram_addr];
            for (int i = 0; i < 4; i++)
                if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
        end
    end

    // Response monitor: pop the oldest expectation on every completion pulse
    always @(negedge clka) begin
        if (rsta_n && rsp_valid) begin
            exp_t e;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_rsp rdata=%h mis=%b", rsp_rdata, rsp_misalign);
            end else begin
                e = sb.pop_front();
                if (rsp_rdata !== e.rdata) begin
                    bad++;
                    $display("FAIL rsp_rdata got=%h exp=%h", rsp_rdata, e.rdata);
                end
                total++;
                if (rsp_misalign !== e.mis) begin
                    bad++;
                    $display("FAIL rsp_misalign got=%b exp=%b", rsp_misalign, e.mis);
                end
                total++;
                if (cyc + 1 - e.hs !== e.lat) begin
                    bad++;
                    $display("FAIL rsp_latency got=%0d exp=%0d", cyc + 1 - e.hs, e.lat);
                end
            end
        end
    end

    task automatic send(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic exp_en, input logic [3:0] exp_we, input logic [31:0] exp_din,
                        input logic [31:0] exp_rd, input logic exp_mis);
        int n;
        logic [9:0] exp_addr;
        n = 0;
        exp_addr = a[11:2];
        @(negedge clka);
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clka);
            n++;
        end
        total++;
        if (n >= 20) begin
            bad++;
            $display("FAIL ready_timeout addr=%h got=%b exp=1", a, req_ready);
            return;
        end
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
        req_valid = 1'b1;
        sb.push_back('{exp_rd, exp_mis, cyc + 1, exp_mis ? 1 : 2});
        @(posedge clka);
        #1;
        req_valid = 1'b0;
        req_addr = $urandom; req_wdata = $urandom;
        req_write = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        total++;
        if (ram_en !== exp_en || ram_we !== exp_we) begin
            bad++;
            $display("FAIL ram_ctrl addr=%h got en=%b we=%b exp en=%b we=%b", a, ram_en, ram_we, exp_en, exp_we);
        end
        if (exp_en) begin
            total++;
            if (ram_addr !== exp_addr) begin
                bad++;
                $display("FAIL ram_addr got=%h exp=%h", ram_addr, exp_addr);
            end
        end
        if (exp_en && w) begin
            total++;
            if (ram_din !== exp_din) begin
                bad++;
                $display("FAIL ram_din got=%h exp=%h", ram_din, exp_din);
            end
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clka);
            n++;
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL rsp_timeout pending got=%0d exp=0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        #1 rsta_n = 1'b0;
        #12;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready got=%b exp=1", req_ready);
        end
        total++;
        if ({rsp_valid, rsp_rdata, rsp_misalign, ram_en, ram_we, ram_addr, ram_din} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got v=%b rd=%h m=%b en=%b we=%b a=%h din=%h exp all zero",
                     rsp_valid, rsp_rdata, rsp_misalign, ram_en, ram_we, ram_addr, ram_din);
        end
        @(negedge clka);
        rsta_n = 1'b1;
    endtask

    task automatic test_word();
        send(1'b1, 2'b10, 1'b0, 32'h40, 32'hDEADBEEF, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0, 1'b0);
        wait_idle();
        send(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 1'b1, 4'h0, 32'h0, 32'hDEADBEEF, 1'b0);
        wait_idle();
    endtask

    task automatic test_byte();
        send(1'b1, 2'b00, 1'b0, 32'h43, 32'hABCDEF80, 1'b1, 4'b1000, 32'h80808080, 32'h0, 1'b0);
        wait_idle();
        send(1'b0, 2'b00, 1'b0, 32'h43, 32'h0, 1'b1, 4'h0, 32'h0, 32'hFFFFFF80, 1'b0);
        wait_idle();
        send(1'b0, 2'b00, 1'b1, 32'h43, 32'h0, 1'b1, 4'h0, 32'h0, 32'h00000080, 1'b0);
        wait_idle();
        send(1'b0, 2'b00, 1'b0, 32'h41, 32'h0, 1'b1, 4'h0, 32'h0, 32'hFFFFFFBE, 1'b0);
        wait_idle();
    endtask

    task automatic test_half();
        send(1'b1, 2'b01, 1'b0, 32'h22, 32'h55558234, 1'b1, 4'b1100, 32'h82348234, 32'h0, 1'b0);
        wait_idle();
        send(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, 1'b1, 4'h0, 32'h0, 32'hFFFF8234, 1'b0);
        wait_idle();
        send(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 1'b1, 4'h0, 32'h0, 32'h00008234, 1'b0);
        wait_idle();
        send(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 1'b1, 4'h0, 32'h0, 32'h82340000, 1'b0);
        wait_idle();
    endtask

    task automatic test_misalign();
        @(negedge clka);
        en_seen = 1'b0;
        send(1'b0, 2'b10, 1'b0, 32'h42, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        wait_idle();
        send(1'b1, 2'b01, 1'b0, 32'h41, 32'hFFFF, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        wait_idle();
        send(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1);
        wait_idle();
        total++;
        if (en_seen !== 1'b0) begin
            bad++;
            $display("FAIL misalign_ram_en got=%b exp=0", en_seen);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        logic [31:0] datas [3];
        int k;
        addrs[0] = 32'h40; datas[0] = 32'h80ADBEEF;
        addrs[1] = 32'h20; datas[1] = 32'h82340000;
        addrs[2] = 32'h44; datas[2] = 32'h00000000;
        k = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clka);
            total++;
            if (req_ready !== (i % 3 == 0)) begin
                bad++;
                $display("FAIL b2b_ready cycle=%0d got=%b exp=%b", i, req_ready, (i % 3 == 0));
            end
            if (req_ready === 1'b1 && k < 3) begin
                req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
                req_addr = addrs[k]; req_valid = 1'b1;
                sb.push_back('{datas[k], 1'b0, cyc + 1, 2});
                k++;
            end
        end
        req_valid = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset_cancel();
        send(1'b1, 2'b10, 1'b0, 32'h50, 32'h11111111, 1'b1, 4'hF, 32'h11111111, 32'h0, 1'b0);
        wait_idle();
        send(1'b1, 2'b10, 1'b0, 32'h50, 32'h22222222, 1'b1, 4'hF, 32'h22222222, 32'h0, 1'b0);
        #1 rsta_n = 1'b0;
        #1;
        sb.delete();
        total++;
        if (ram_we !== 4'h0 || ram_en !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_cancel got we=%b en=%b rdy=%b v=%b exp we=0 en=0 rdy=1 v=0",
                     ram_we, ram_en, req_ready, rsp_valid);
        end
        @(negedge clka);
        #1 rsta_n = 1'b1;
        send(1'b0, 2'b10, 1'b0, 32'h50, 32'h0, 1'b1, 4'h0, 32'h0, 32'h11111111, 1'b0);
        wait_idle();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_misalign();
        test_back_to_back();
        test_reset_cancel();
        repeat (3) @(posedge clka);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
